// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolution stage: MIPS-32 opcode and
// REGIMM rt encodings, the 2-bit PHT counter states, the registered
// result bundle and the saturating counter update.
package branch_resolve_unit_pkg;

    // Primary opcode field encodings
    localparam logic [5:0] EXE_REGIMM_INST = 6'b000001;
    localparam logic [5:0] EXE_BEQ         = 6'b000100;
    localparam logic [5:0] EXE_BNE         = 6'b000101;
    localparam logic [5:0] EXE_BLEZ        = 6'b000110;
    localparam logic [5:0] EXE_BGTZ        = 6'b000111;
    localparam logic [5:0] EXE_BEQL        = 6'b010100;
    localparam logic [5:0] EXE_BNEL        = 6'b010101;
    localparam logic [5:0] EXE_BLEZL       = 6'b010110;
    localparam logic [5:0] EXE_BGTZL       = 6'b010111;

    // REGIMM sub-op encodings carried in the rt field
    localparam logic [4:0] EXE_BLTZ   = 5'b00000;
    localparam logic [4:0] EXE_BGEZ   = 5'b00001;
    localparam logic [4:0] EXE_BLTZL  = 5'b00010;
    localparam logic [4:0] EXE_BGEZL  = 5'b00011;
    localparam logic [4:0] EXE_BLTZAL = 5'b10000;
    localparam logic [4:0] EXE_BGEZAL = 5'b10001;

    // 2-bit saturating counter states; the MSB is the taken prediction
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } pht_ctr_e;

    // Result bundle registered into EX
    typedef struct packed {
        logic valid;
        logic is_branch;
        logic taken;
        logic link;
        logic mispredict;
        logic nullify;
    } br_out_t;

    // Move a counter one step towards the resolved direction, saturating at both ends
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Decode-side bus of the branch resolution stage. The pipeline drives the
// master side; branch_resolve_unit sits on the slave side.
interface branch_resolve_unit_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              stall_i;
    logic              flush_i;
    logic              valid_i;
    logic [5:0]        op_i;
    logic [4:0]        rt_i;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic [PC_W-1:0]   pc_i;
    logic              pred_taken_i;
    logic [PC_W-1:0]   fetch_pc_i;
    logic              predict_taken_o;
    logic              valid_o;
    logic              is_branch_o;
    logic              taken_o;
    logic              link_o;
    logic              mispredict_o;
    logic              nullify_o;

    modport master (
        output stall_i, flush_i, valid_i, op_i, rt_i, a_i, b_i, pc_i,
               pred_taken_i, fetch_pc_i,
        input  predict_taken_o, valid_o, is_branch_o, taken_o, link_o,
               mispredict_o, nullify_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, op_i, rt_i, a_i, b_i, pc_i,
               pred_taken_i, fetch_pc_i,
        output predict_taken_o, valid_o, is_branch_o, taken_o, link_o,
               mispredict_o, nullify_o
    );
endinterface

// File: rtl/branch_resolve_unit_cond.sv
// Combinational branch decoder and condition evaluator (branch_cond_eval).
// Optional macro BRANCH_LIKELY_EN adds the branch-likely encodings; when it is
// undefined those encodings decode as non-branches and likely_o stays 0.
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        op_i,
    input  logic [4:0]        rt_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              is_branch_o,
    output logic              taken_o,
    output logic              link_o,
    output logic              likely_o
);

    logic sign;
    logic a_zero;
    logic a_eq_b;

    assign sign   = a_i[DATA_W-1];
    assign a_zero = (a_i == '0);
    assign a_eq_b = (a_i == b_i);

    // Decode op/rt into branch class and evaluate its condition
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves one unassigned and infers a latch.
        is_branch_o = 1'b0;
        taken_o     = 1'b0;
        link_o      = 1'b0;
        likely_o    = 1'b0;
        unique case (op_i)
            EXE_BEQ:  begin is_branch_o = 1'b1; taken_o = a_eq_b;          end
            EXE_BNE:  begin is_branch_o = 1'b1; taken_o = !a_eq_b;         end
            EXE_BLEZ: begin is_branch_o = 1'b1; taken_o = sign || a_zero;  end
            EXE_BGTZ: begin is_branch_o = 1'b1; taken_o = !sign && !a_zero; end
`ifdef BRANCH_LIKELY_EN
            EXE_BEQL:  begin is_branch_o = 1'b1; likely_o = 1'b1; taken_o = a_eq_b;           end
            EXE_BNEL:  begin is_branch_o = 1'b1; likely_o = 1'b1; taken_o = !a_eq_b;          end
            EXE_BLEZL: begin is_branch_o = 1'b1; likely_o = 1'b1; taken_o = sign || a_zero;   end
            EXE_BGTZL: begin is_branch_o = 1'b1; likely_o = 1'b1; taken_o = !sign && !a_zero; end
`endif
            EXE_REGIMM_INST: begin
                unique case (rt_i)
                    EXE_BLTZ:   begin is_branch_o = 1'b1; taken_o = sign;  end
                    EXE_BGEZ:   begin is_branch_o = 1'b1; taken_o = !sign; end
                    EXE_BLTZAL: begin is_branch_o = 1'b1; taken_o = sign;  link_o = 1'b1; end
                    EXE_BGEZAL: begin is_branch_o = 1'b1; taken_o = !sign; link_o = 1'b1; end
`ifdef BRANCH_LIKELY_EN
                    EXE_BLTZL:  begin is_branch_o = 1'b1; taken_o = sign;  likely_o = 1'b1; end
                    EXE_BGEZL:  begin is_branch_o = 1'b1; taken_o = !sign; likely_o = 1'b1; end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage at the decode/execute boundary: evaluates the
// branch condition, registers the outcome into EX one cycle later, flags
// mispredicts and trains a PC-indexed table of 2-bit counters that serves
// the fetch-time prediction. Optional macro BRANCH_LIKELY_EN enables the
// branch-likely ops and the nullify output.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         PC_W      = 32,
    parameter int         PHT_DEPTH = 64,
    parameter logic [1:0] PHT_INIT  = 2'b01
) (
    input  logic                clk,
    input  logic                rst,
    branch_resolve_unit_if.slave bus
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    logic              br_is_branch;
    logic              br_taken;
    logic              br_link;
    logic              br_likely;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              pht_we;
    logic [1:0]        pht [PHT_DEPTH];
    br_out_t           out_d;
    br_out_t           out_q;
    logic              unused_pc_bits;

    branch_cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond (
        .op_i        (bus.op_i),
        .rt_i        (bus.rt_i),
        .a_i         (bus.a_i),
        .b_i         (bus.b_i),
        .is_branch_o (br_is_branch),
        .taken_o     (br_taken),
        .link_o      (br_link),
        .likely_o    (br_likely)
    );

    // Word-aligned PCs: the two byte-offset bits are skipped in the index
    assign rd_idx         = bus.fetch_pc_i[IDX_W+1:2];
    assign wr_idx         = bus.pc_i[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.fetch_pc_i, bus.pc_i};

    // Asynchronous read: a same-cycle update to this entry shows up next cycle
    assign bus.predict_taken_o = pht[rd_idx][1];

    assign pht_we = bus.valid_i && br_is_branch && !bus.stall_i && !bus.flush_i;

    // Result to be captured, with every flag qualified by the incoming valid
    always_comb begin
        out_d            = '0;
        out_d.valid      = bus.valid_i;
        out_d.is_branch  = bus.valid_i && br_is_branch;
        out_d.taken      = bus.valid_i && br_taken;
        out_d.link       = bus.valid_i && br_link;
        out_d.mispredict = bus.valid_i && br_is_branch && (br_taken != bus.pred_taken_i);
        out_d.nullify    = bus.valid_i && br_likely && !br_taken;
    end

    // EX output register: reset beats stall, stall beats flush
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of block order.
        if (rst) begin
            out_q <= '0;
        end else if (!bus.stall_i) begin
            out_q <= bus.flush_i ? '0 : out_d;
        end
    end

    // Pattern history table: full reinitialisation on reset, training on capture
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is built from flops, so it can be cleared in one cycle; a RAM-mapped table would need a sweep instead.
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= PHT_INIT;
            end
        end else if (pht_we) begin
            pht[wr_idx] <= ctr_next(pht[wr_idx], br_taken);
        end
    end

    assign bus.valid_o      = out_q.valid;
    assign bus.is_branch_o  = out_q.is_branch;
    assign bus.taken_o      = out_q.taken;
    assign bus.link_o       = out_q.link;
    assign bus.mispredict_o = out_q.mispredict;
    assign bus.nullify_o    = out_q.nullify;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a vector table drives the
// 32-bit instance cycle by cycle, expected registered results go through a
// scoreboard queue, and a short hand sequence exercises a 16-bit instance.
// Expectations follow BRANCH_LIKELY_EN when it is defined for the build.
module tb_branch_resolve_unit;

    typedef struct packed {
        logic v, br, tk, lk, mp, nu;
    } out_t;

    typedef struct {
        logic        rst, stall, flush, valid;
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [31:0] a, b, pc;
        logic        pred;
        logic [31:0] fpc;
        logic        exp_pred;
        out_t        exp;
    } vec_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_BEQL    = 6'b010100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.DATA_W(32), .PC_W(32)) bus ();
    branch_resolve_unit_if #(.DATA_W(16), .PC_W(32)) bus16 ();

    branch_resolve_unit #(.DATA_W(32), .PC_W(32), .PHT_DEPTH(64), .PHT_INIT(2'b01)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    branch_resolve_unit #(.DATA_W(16), .PC_W(32), .PHT_DEPTH(64), .PHT_INIT(2'b01)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    vec_t tbl[$];
    out_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic out_t o(input logic v, br, tk, lk, mp, nu);
        return {v, br, tk, lk, mp, nu};
    endfunction

    function automatic out_t dut_out();
        return {bus.valid_o, bus.is_branch_o, bus.taken_o, bus.link_o, bus.mispredict_o, bus.nullify_o};
    endfunction

    task automatic add(input logic r, st, fl, v, input logic [5:0] op, input logic [4:0] rt,
                       input logic [31:0] a, b, pc, input logic pred, input logic [31:0] fpc,
                       input logic ep, input out_t e);
        vec_t t;
        t.rst = r; t.stall = st; t.flush = fl; t.valid = v;
        t.op = op; t.rt = rt; t.a = a; t.b = b; t.pc = pc; t.pred = pred;
        t.fpc = fpc; t.exp_pred = ep; t.exp = e;
        tbl.push_back(t);
    endtask

    task automatic apply(input vec_t t);
        rst              = t.rst;
        bus.stall_i      = t.stall;
        bus.flush_i      = t.flush;
        bus.valid_i      = t.valid;
        bus.op_i         = t.op;
        bus.rt_i         = t.rt;
        bus.a_i          = t.a;
        bus.b_i          = t.b;
        bus.pc_i         = t.pc;
        bus.pred_taken_i = t.pred;
        bus.fetch_pc_i   = t.fpc;
    endtask

    task automatic idle16();
        bus16.stall_i = 1'b0; bus16.flush_i = 1'b0; bus16.valid_i = 1'b0;
        bus16.op_i = '0; bus16.rt_i = '0; bus16.a_i = '0; bus16.b_i = '0;
        bus16.pc_i = '0; bus16.pred_taken_i = 1'b0; bus16.fetch_pc_i = '0;
    endtask

    initial begin
        out_t N;
        out_t got;
        vec_t idle_v;
        N = o(0, 0, 0, 0, 0, 0);

        //   rst st fl v  op          rt        a             b      pc        p  fetch     ep exp
        add(1, 0, 0, 1, OP_BEQ,     5'b00000, 32'h5,        32'h5, 32'h100, 0, 32'h100, 0, N);                   // reset wins, no training
        add(0, 0, 0, 1, OP_BEQ,     5'b00000, 32'h5,        32'h5, 32'h100, 0, 32'h100, 0, o(1,1,1,0,1,0));      // 01->10, old value read
        add(0, 0, 0, 1, OP_BEQ,     5'b00000, 32'h5,        32'h5, 32'h100, 1, 32'h100, 1, o(1,1,1,0,0,0));      // 10->11
        add(0, 0, 0, 1, OP_BEQ,     5'b00000, 32'h5,        32'h5, 32'h100, 1, 32'h100, 1, o(1,1,1,0,0,0));      // saturate 11
        add(0, 0, 0, 1, OP_BEQ,     5'b00000, 32'h5,        32'h5, 32'h100, 1, 32'h100, 1, o(1,1,1,0,0,0));      // saturate 11
        add(0, 0, 0, 1, OP_BEQ,     5'b00000, 32'h5,        32'h6, 32'h100, 1, 32'h100, 1, o(1,1,0,0,1,0));      // 11->10
        add(0, 0, 0, 0, OP_SPECIAL, 5'b00000, 32'h0,        32'h0, 32'h0,   0, 32'h100, 1, N);                   // still predicts taken
        add(0, 0, 0, 1, OP_BNE,     5'b00000, 32'h3,        32'h3, 32'h104, 0, 32'h104, 0, o(1,1,0,0,0,0));      // 01->00
        add(0, 0, 0, 1, OP_BNE,     5'b00000, 32'h3,        32'h3, 32'h104, 0, 32'h104, 0, o(1,1,0,0,0,0));      // saturate 00
        add(0, 0, 0, 1, OP_BNE,     5'b00000, 32'h1,        32'h2, 32'h104, 0, 32'h104, 0, o(1,1,1,0,1,0));      // 00->01
        add(0, 0, 0, 0, OP_SPECIAL, 5'b00000, 32'h0,        32'h0, 32'h0,   0, 32'h104, 0, N);
        add(0, 0, 0, 1, OP_REGIMM,  5'b10001, 32'h80000000, 32'h0, 32'h108, 0, 32'h108, 0, o(1,1,0,1,0,0));      // BGEZAL negative
        add(0, 0, 0, 1, OP_REGIMM,  5'b10000, 32'h80000000, 32'h0, 32'h108, 0, 32'h108, 0, o(1,1,1,1,1,0));      // BLTZAL negative
        add(0, 0, 0, 1, OP_REGIMM,  5'b00001, 32'h0,        32'h0, 32'h10C, 1, 32'h10C, 0, o(1,1,1,0,0,0));      // BGEZ zero
        add(0, 0, 0, 1, OP_REGIMM,  5'b00000, 32'h1,        32'h0, 32'h10C, 0, 32'h10C, 1, o(1,1,0,0,0,0));      // BLTZ positive
        add(0, 0, 0, 1, OP_BLEZ,    5'b00000, 32'h0,        32'h0, 32'h110, 0, 32'h110, 0, o(1,1,1,0,1,0));      // BLEZ zero
        add(0, 0, 0, 1, OP_BLEZ,    5'b00000, 32'hFFFFFFFF, 32'h0, 32'h110, 0, 32'h110, 1, o(1,1,1,0,1,0));      // BLEZ negative
        add(0, 0, 0, 1, OP_BGTZ,    5'b00000, 32'h0,        32'h0, 32'h114, 0, 32'h114, 0, o(1,1,0,0,0,0));      // BGTZ zero
        add(0, 0, 0, 1, OP_BGTZ,    5'b00000, 32'h1,        32'h0, 32'h114, 1, 32'h114, 0, o(1,1,1,0,0,0));      // BGTZ positive
        add(0, 0, 0, 1, OP_BGTZ,    5'b00000, 32'h80000000, 32'h0, 32'h114, 0, 32'h114, 0, o(1,1,0,0,0,0));      // BGTZ negative
        add(0, 0, 0, 1, OP_REGIMM,  5'b00100, 32'h80000000, 32'h0, 32'h114, 1, 32'h114, 0, o(1,0,0,0,0,0));      // unknown rt
        add(0, 0, 0, 1, OP_SPECIAL, 5'b00000, 32'h5,        32'h5, 32'h100, 1, 32'h100, 1, o(1,0,0,0,0,0));      // non-branch op
        add(0, 0, 0, 0, OP_BEQ,     5'b00000, 32'h1,        32'h2, 32'h100, 1, 32'h100, 1, N);                   // invalid: no training
        add(0, 0, 0, 0, OP_SPECIAL, 5'b00000, 32'h0,        32'h0, 32'h0,   0, 32'h100, 1, N);
        add(0, 0, 0, 1, OP_BNE,     5'b00000, 32'h1,        32'h2, 32'h100, 0, 32'h100, 1, o(1,1,1,0,1,0));      // 10->11
        add(0, 1, 0, 1, OP_BNE,     5'b00000, 32'h7,        32'h7, 32'h100, 0, 32'h100, 1, o(1,1,1,0,1,0));      // stall holds
        add(0, 1, 0, 1, OP_BNE,     5'b00000, 32'h7,        32'h7, 32'h100, 0, 32'h100, 1, o(1,1,1,0,1,0));      // stall holds
        add(0, 0, 1, 1, OP_BNE,     5'b00000, 32'h7,        32'h7, 32'h100, 0, 32'h100, 1, N);                   // flush kills
        add(0, 0, 1, 1, OP_BNE,     5'b00000, 32'h7,        32'h7, 32'h100, 0, 32'h100, 1, N);                   // flush kills
        add(0, 0, 0, 0, OP_SPECIAL, 5'b00000, 32'h0,        32'h0, 32'h0,   0, 32'h100, 1, N);                   // still 11
`ifdef BRANCH_LIKELY_EN
        add(0, 0, 0, 1, OP_BEQL,    5'b00000, 32'h1,        32'h2, 32'h118, 0, 32'h118, 0, o(1,1,0,0,0,1));      // likely not taken
        add(0, 0, 0, 1, OP_BEQL,    5'b00000, 32'h3,        32'h3, 32'h118, 0, 32'h118, 0, o(1,1,1,0,1,0));      // likely taken
`else
        add(0, 0, 0, 1, OP_BEQL,    5'b00000, 32'h1,        32'h2, 32'h118, 0, 32'h118, 0, o(1,0,0,0,0,0));      // not a branch
        add(0, 0, 0, 1, OP_BEQL,    5'b00000, 32'h3,        32'h3, 32'h118, 0, 32'h118, 0, o(1,0,0,0,0,0));      // not a branch
`endif
        add(0, 0, 0, 1, OP_BEQ,     5'b00000, 32'h4,        32'h4, 32'h11C, 0, 32'h118, 0, o(1,1,1,0,1,0));      // idx7 01->10
        add(1, 1, 0, 0, OP_SPECIAL, 5'b00000, 32'h0,        32'h0, 32'h0,   0, 32'h11C, 1, N);                   // reset beats stall
        add(0, 0, 0, 0, OP_SPECIAL, 5'b00000, 32'h0,        32'h0, 32'h0,   0, 32'h11C, 0, N);                   // table reinitialised

        // Initial reset of both instances
        idle_v = tbl[6];
        idle_v.rst = 1'b1;
        apply(idle_v);
        idle16();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.fetch_pc_i = 32'h100;
        #1;
        check("reset_predict", 0, 32'(bus.predict_taken_o), 32'd0);
        check("reset_outputs", 0, 32'(dut_out()), 32'd0);

        // Table-driven run through the scoreboard
        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            exp_q.push_back(tbl[i].exp);
            #1;
            check("predict", i, 32'(bus.predict_taken_o), 32'(tbl[i].exp_pred));
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            check("outputs", i, 32'(dut_out()), 32'(got));
        end

        // 16-bit instance: sign bit is bit 15
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus16.valid_i = 1'b1; bus16.op_i = OP_REGIMM; bus16.rt_i = 5'b10001;
        bus16.a_i = 16'h7FFF; bus16.pc_i = 32'h100; bus16.fetch_pc_i = 32'h100;
        bus16.pred_taken_i = 1'b0;
        @(posedge clk);
        #1;
        check("w16_taken", 0, 32'(bus16.taken_o), 32'd1);
        check("w16_link", 0, 32'(bus16.link_o), 32'd1);
        check("w16_mispredict", 0, 32'(bus16.mispredict_o), 32'd1);
        @(negedge clk);
        bus16.a_i = 16'h8000;
        #1;
        check("w16_predict", 1, 32'(bus16.predict_taken_o), 32'd1);
        @(posedge clk);
        #1;
        check("w16_taken", 1, 32'(bus16.taken_o), 32'd0);
        check("w16_link", 1, 32'(bus16.link_o), 32'd1);
        check("w16_mispredict", 1, 32'(bus16.mispredict_o), 32'd0);
        @(negedge clk);
        bus16.valid_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised branch resolution stage for the MIPS-32 pipeline, placed at the decode/execute boundary.
- Evaluates branch conditions at generic data width and registers the outcome into EX with 1-cycle latency.
- Contains a PC-indexed pattern history table (PHT) of 2-bit saturating counters, which provides a fetch-time prediction.
- Flags mispredicts against the prediction carried down the pipe.

Parameters:
- DATA_W, 32, operand width; the sign bit is bit DATA_W-1.
- PC_W, 32, program counter width.
- PHT_DEPTH, 64, number of PHT entries; must be a power of 2, minimum 2.
- PHT_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stall_i  in  1  hold the output registers; no PHT update.
- flush_i  in  1  kill the instruction being registered.
- valid_i  in  1  D-stage instruction valid.
- op_i  in  6  opcode field.
- rt_i  in  5  rt field (REGIMM sub-op).
- a_i  in  DATA_W  rs operand, already forwarded.
- b_i  in  DATA_W  rt operand, already forwarded.
- pc_i  in  PC_W  PC of the D-stage instruction.
- pred_taken_i  in  1  prediction made at fetch for this instruction.
- fetch_pc_i  in  PC_W  PC being fetched.
- predict_taken_o  out  1  combinational PHT prediction for fetch_pc_i.
- valid_o  out  1  registered: result valid.
- is_branch_o  out  1  registered: instruction is a recognised branch.
- taken_o  out  1  registered: branch condition true.
- link_o  out  1  registered: link variant (BLTZAL/BGEZAL).
- mispredict_o  out  1  registered: valid_o & is_branch_o & (taken_o != registered pred_taken).
- nullify_o  out  1  registered: branch-likely not taken (see Optional Feature).

Behaviour:
- Reset: all registered outputs are 0. Every PHT entry is set to PHT_INIT. predict_taken_o follows the reset PHT value, i.e. the counter MSB.
- PHT index: pc[IDX_W+1:2], where IDX_W = log2(PHT_DEPTH). The same slice of fetch_pc_i is used for reads.
- predict_taken_o is the MSB of the indexed counter. The read is asynchronous.
- Conditions:
  - BEQ 000100: a==b.
  - BNE 000101: a!=b.
  - BLEZ 000110: sign=1 or a==0.
  - BGTZ 000111: sign=0 and a!=0.
  - REGIMM 000001 with rt BLTZ 00000 or BLTZAL 10000: sign=1.
  - REGIMM 000001 with rt BGEZ 00001 or BGEZAL 10001: sign=0.
- Any other op, or any other REGIMM rt: is_branch=0, taken=0, link=0.
- link_o is set for AL variants regardless of taken.
- Output registers:
  - rst: clear all.
  - else if stall_i: hold all.
  - else if flush_i: valid_o=0 and all other flags 0.
  - else: capture valid_i, and each flag ANDed with valid_i.
- PHT update occurs on the same edge as the capture, when valid_i & is_branch & !stall_i & !flush_i & !rst.
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
- Same-cycle read and write to the same index: predict_taken_o shows the old value; the new value is visible the next cycle.
- Reset mid-operation takes priority over stall and flush. The PHT is fully reinitialised within 1 cycle.

Optional Feature:
- Macro: BRANCH_LIKELY_EN.
- Defined: the unit also decodes the branch-likely ops.
  - BEQL 010100, BNEL 010101, BLEZL 010110, BGTZL 010111 use the same conditions as their base ops.
  - REGIMM BLTZL 00010 and BGEZL 00011 use the same conditions as BLTZ and BGEZ.
  - nullify_o = valid & likely & !taken.
  - Likely branches update the PHT like normal branches.
- Undefined: these encodings are non-branches, and nullify_o is constant 0. The port still exists.

Decomposition:
- Shared defines package: opcode constants (EXE_BEQ … EXE_REGIMM_INST, likely variants), REGIMM rt constants, and the 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11).
- Sub-module: branch_cond_eval. Combinational; parametrised by DATA_W; takes op, rt, a, b; produces is_branch, taken, link, likely.
- Top level holds the PHT, the output registers and the mispredict logic.

Test Plan:
- Reset, then query fetch_pc_i=0x100: predict_taken_o=0. Every output is 0 on the cycle after reset.
- BEQ, a=b=0x5, pred_taken_i=0, pc=0x100: next cycle valid_o=1, taken_o=1, mispredict_o=1. PHT[0x40 mod 64] goes 01→10, so predict_taken_o=1 for fetch_pc 0x100.
- Three taken branches at the same PC: counter saturates at 11. One not-taken follows: counter=10 and prediction is still 1.
- BGEZAL with a=0x80000000: taken_o=0 and link_o=1. Repeat with DATA_W=16 and a=0x7FFF: taken_o=1.
- BNE asserted together with stall_i=1 for 2 cycles: outputs hold and the PHT is unchanged. With flush_i=1 instead: valid_o=0 and no PHT update.
- BRANCH_LIKELY_EN defined: BEQL with a=1, b=2 gives nullify_o=1 and taken_o=0. Same stimulus without the macro gives is_branch_o=0 and nullify_o=0.
